bp_branch_predictor: RTL and testbench

- Dynamic branch predictor feeding the fetch stage of the pipelined MIPS core.
- Holds a direct-mapped table of 2-bit saturating counters plus a small branch target buffer (BTB).
- In IF: a combinational lookup on the fetch PC gives predict_taken / predict_target.
- From ID: resolved BEQ/BNE outcomes train the table and update prediction-accuracy statistics counters.

---
 rtl/bp_branch_predictor_pkg.sv | 31 +++
 rtl/bp_branch_predictor_if.sv | 36 +++
 rtl/bp_sat_ctr2.sv | 26 ++
 rtl/bp_branch_predictor.sv | 119 +++++++++++
 tb/tb_bp_branch_predictor.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
//   - Default geometry (table index width, PC width, statistics width).
//   - 2-bit saturating counter encoding and its reset value.
//   - Small helpers used by the predictor datapath.
package bp_branch_predictor_pkg;

  localparam int BP_IDX_BITS = 4;   // log2 of table entries
  localparam int BP_WORD_LEN = 32;  // PC / target width
  localparam int BP_STAT_W   = 32;  // statistics counter width

  // Counter encoding: the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } bp_ctr_e;

  localparam bp_ctr_e CTR_RESET = CTR_WNT;
  localparam bp_ctr_e CTR_ALLOC = CTR_WT;

  function automatic logic ctr_is_taken(input bp_ctr_e ctr);
    return (ctr == CTR_WT) || (ctr == CTR_ST);
  endfunction

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [BP_STAT_W-1:0] sat_inc(input logic [BP_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bp_branch_predictor_if.sv
// Bundle between the fetch/decode stages and the branch predictor.
//   master : pipeline side (drives lookup PC, resolved-branch updates,
//            enable and stats clear; receives predictions and statistics)
//   slave  : predictor side
interface bp_branch_predictor_if #(
  parameter int WORD_LEN = 32
);
  // Fetch-stage lookup
  logic                bp_enable;
  logic [WORD_LEN-1:0] lookup_pc;
  logic                predict_taken;
  logic [WORD_LEN-1:0] predict_target;
  // Decode-stage training
  logic                update_en;
  logic [WORD_LEN-1:0] update_pc;
  logic                update_taken;
  logic [WORD_LEN-1:0] update_target;
  logic                update_predicted;
  // Accuracy statistics
  logic                stats_clear;
  logic [31:0]         bp_total;
  logic [31:0]         bp_correct;
  logic [31:0]         bp_wrong;

  modport master (
    output bp_enable, lookup_pc, update_en, update_pc, update_taken,
           update_target, update_predicted, stats_clear,
    input  predict_taken, predict_target, bp_total, bp_correct, bp_wrong
  );

  modport slave (
    input  bp_enable, lookup_pc, update_en, update_pc, update_taken,
           update_target, update_predicted, stats_clear,
    output predict_taken, predict_target, bp_total, bp_correct, bp_wrong
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// Next-state function of a 2-bit saturating branch counter.
//   ctr_in  : current counter value
//   taken   : resolved branch outcome
//   ctr_out : counter moved one step toward the outcome, saturating at
//             strongly-taken / strongly-not-taken
module bp_sat_ctr2
  import bp_branch_predictor_pkg::*;
(
  input  bp_ctr_e ctr_in,
  input  logic    taken,
  output bp_ctr_e ctr_out
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives ctr_out;
    // otherwise synthesis infers a latch for uncovered paths.
    ctr_out = ctr_in;
    unique case (ctr_in)
      CTR_SNT: ctr_out = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_out = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_out = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_out = taken ? CTR_ST  : CTR_WT;
    endcase
  end

endmodule

// File: rtl/bp_branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with a tagged target buffer.
//   clk, rst     : core clock, asynchronous active-low reset
//   bp (slave)   : lookup_pc -> predict_taken/predict_target (combinational);
//                  update_* trains the table on the clock edge;
//                  bp_total/bp_correct/bp_wrong accuracy counters with a
//                  synchronous stats_clear.
// Entry index is pc[IDX_BITS+1:2]; the remaining upper PC bits form the tag.
module bp_branch_predictor
  import bp_branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int WORD_LEN = BP_WORD_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  bp_branch_predictor_if.slave   bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_LEN - IDX_BITS - 2;

  // Table storage
  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [WORD_LEN-1:0] target_q [ENTRIES];
  bp_ctr_e             ctr_q    [ENTRIES];

  // Statistics
  logic [BP_STAT_W-1:0] total_q;
  logic [BP_STAT_W-1:0] correct_q;
  logic [BP_STAT_W-1:0] wrong_q;

  // ---------------------------------------------------------------------
  // Lookup: reads the registered table only, so an update in the same
  // cycle is not visible until the next one.
  // ---------------------------------------------------------------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;

  assign lk_idx = bp.lookup_pc[IDX_BITS+1:2];
  assign lk_tag = bp.lookup_pc[WORD_LEN-1:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bp.predict_taken  = bp.bp_enable && lk_hit && ctr_is_taken(ctr_q[lk_idx]);
  assign bp.predict_target = lk_hit ? target_q[lk_idx] : '0;

  // ---------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                upd_correct;
  bp_ctr_e             ctr_next;

  assign upd_idx     = bp.update_pc[IDX_BITS+1:2];
  assign upd_tag     = bp.update_pc[WORD_LEN-1:IDX_BITS+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_correct = (bp.update_predicted == bp.update_taken);

  bp_sat_ctr2 u_sat_ctr (
    .ctr_in  (ctr_q[upd_idx]),
    .taken   (bp.update_taken),
    .ctr_out (ctr_next)
  );

  // Word-aligned PCs: the byte-offset bits carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is reset entry by entry (valid bits and counters
      // must start in a known state), so it maps to flops, not a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (bp.update_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
        if (bp.update_taken) target_q[upd_idx] <= bp.update_target;
      end else if (bp.update_taken) begin
        // Miss on a taken branch: claim the slot, evicting any alias.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bp.update_target;
        ctr_q[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

  // Clear wins over a same-cycle count; table training above is unaffected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      total_q   <= '0;
      correct_q <= '0;
      wrong_q   <= '0;
    end else if (bp.stats_clear) begin
      total_q   <= '0;
      correct_q <= '0;
      wrong_q   <= '0;
    end else if (bp.update_en) begin
      total_q <= sat_inc(total_q);
      if (upd_correct) correct_q <= sat_inc(correct_q);
      else             wrong_q   <= sat_inc(wrong_q);
    end
  end

  assign bp.bp_total   = total_q;
  assign bp.bp_correct = correct_q;
  assign bp.bp_wrong   = wrong_q;

endmodule

// File: tb/tb_bp_branch_predictor.sv
// Self-checking bench for bp_branch_predictor: directed scenarios with
// literal expectations, then a randomized phase against a behavioural model.
module tb_bp_branch_predictor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_branch_predictor_if #(.WORD_LEN(32)) bp_if ();

  bp_branch_predictor #(.IDX_BITS(4), .WORD_LEN(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .bp  (bp_if.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          ctr;     // 0..3, prediction taken when >= 2
  } m_entry_t;

  m_entry_t m_tab [16];
  longint   m_total, m_correct, m_wrong;
  localparam longint STAT_MAX = 64'hFFFF_FFFF;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_tab[i].valid  = 0;
      m_tab[i].tag    = 0;
      m_tab[i].target = 0;
      m_tab[i].ctr    = 1;
    end
    m_total = 0; m_correct = 0; m_wrong = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, input bit en,
                                    output logic exp_taken, output logic [31:0] exp_target);
    int  i;
    bit  hit;
    i   = m_idx(pc);
    hit = m_tab[i].valid && (m_tab[i].tag == m_tagof(pc));
    exp_taken  = en && hit && (m_tab[i].ctr >= 2);
    exp_target = hit ? m_tab[i].target : 32'h0;
  endfunction

  function automatic void m_step(input bit upd, input bit clr, input logic [31:0] pc,
                                 input bit taken, input logic [31:0] tgt, input bit pred);
    int i;
    if (upd) begin
      i = m_idx(pc);
      if (m_tab[i].valid && m_tab[i].tag == m_tagof(pc)) begin
        if (taken) begin
          m_tab[i].ctr    = (m_tab[i].ctr < 3) ? m_tab[i].ctr + 1 : 3;
          m_tab[i].target = tgt;
        end else begin
          m_tab[i].ctr = (m_tab[i].ctr > 0) ? m_tab[i].ctr - 1 : 0;
        end
      end else if (taken) begin
        m_tab[i].valid  = 1;
        m_tab[i].tag    = m_tagof(pc);
        m_tab[i].target = tgt;
        m_tab[i].ctr    = 2;
      end
    end
    if (clr) begin
      m_total = 0; m_correct = 0; m_wrong = 0;
    end else if (upd) begin
      m_total = (m_total < STAT_MAX) ? m_total + 1 : STAT_MAX;
      if (pred == taken) m_correct = (m_correct < STAT_MAX) ? m_correct + 1 : STAT_MAX;
      else               m_wrong   = (m_wrong   < STAT_MAX) ? m_wrong   + 1 : STAT_MAX;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive lookup_pc and compare against literal expectations.
  task automatic check_lk(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_target);
    bp_if.lookup_pc = pc;
    #1;
    check({tag, "_taken"},  {31'b0, bp_if.predict_taken}, {31'b0, exp_taken});
    check({tag, "_target"}, bp_if.predict_target, exp_target);
  endtask

  task automatic check_stats(input string tag, input longint t, input longint c, input longint w);
    check({tag, "_total"},   bp_if.bp_total,   t[31:0]);
    check({tag, "_correct"}, bp_if.bp_correct, c[31:0]);
    check({tag, "_wrong"},   bp_if.bp_wrong,   w[31:0]);
  endtask

  // One clocked update (optionally with stats_clear), mirrored into the model.
  task automatic do_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                           input bit pred, input bit clr = 1'b0);
    bp_if.update_en        = 1'b1;
    bp_if.update_pc        = pc;
    bp_if.update_taken     = taken;
    bp_if.update_target    = tgt;
    bp_if.update_predicted = pred;
    bp_if.stats_clear      = clr;
    @(posedge clk);
    m_step(1'b1, clr, pc, taken, tgt, pred);
    #1;
    bp_if.update_en   = 1'b0;
    bp_if.stats_clear = 1'b0;
  endtask

  function automatic logic [31:0] pool_pc();
    return ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
  endfunction

  // Hard time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        et;
    logic [31:0] etg;

    rst_n                  = 1'b0;
    bp_if.bp_enable        = 1'b1;
    bp_if.lookup_pc        = '0;
    bp_if.update_en        = 1'b0;
    bp_if.update_pc        = '0;
    bp_if.update_taken     = 1'b0;
    bp_if.update_target    = '0;
    bp_if.update_predicted = 1'b0;
    bp_if.stats_clear      = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_lk("rst_0x40",   32'h40,   1'b0, 32'h0);
    check_lk("rst_0x1234", 32'h1234, 1'b0, 32'h0);
    check_stats("rst", 0, 0, 0);

    // Mid-run asynchronous reset discards trained state immediately
    @(negedge clk);
    do_update(32'h40,   1'b1, 32'h80,  1'b0);
    do_update(32'h1234, 1'b1, 32'h300, 1'b1);
    check_lk("pre_rst_0x40", 32'h40, 1'b1, 32'h80);
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    check_lk("async_rst_0x40", 32'h40, 1'b0, 32'h0);
    check_stats("async_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_lk("post_rst_0x1234", 32'h1234, 1'b0, 32'h0);

    // Train: first taken allocates at weakly-taken
    @(negedge clk);
    do_update(32'h40, 1'b1, 32'h80, 1'b0);
    check_lk("train", 32'h40, 1'b1, 32'h80);
    check_stats("train", 1, 0, 1);

    // Hysteresis
    repeat (3) do_update(32'h40, 1'b1, 32'h80, 1'b1);
    check_lk("hyst_st", 32'h40, 1'b1, 32'h80);
    check_stats("hyst_st", 4, 3, 0 + 1);
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    check_lk("hyst_nt1", 32'h40, 1'b1, 32'h80);
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    check_lk("hyst_nt2", 32'h40, 1'b0, 32'h80);
    check_stats("hyst_nt2", 6, 3, 3);

    // Aliasing: 0x80 shares index 0 with 0x40
    do_update(32'h40, 1'b1, 32'h80, 1'b0);
    check_lk("alias_own",  32'h40, 1'b1, 32'h80);
    check_lk("alias_miss", 32'h80, 1'b0, 32'h0);
    do_update(32'h80, 1'b1, 32'hC0, 1'b0);
    check_lk("alias_evicted", 32'h40, 1'b0, 32'h0);
    check_lk("alias_new",     32'h80, 1'b1, 32'hC0);
    check_stats("alias", 8, 3, 5);

    // Enable masking: training continues while predictions are masked
    bp_if.bp_enable = 1'b0;
    check_lk("dis_mask", 32'h80, 1'b0, 32'hC0);
    do_update(32'h80, 1'b0, 32'h0, 1'b0);
    do_update(32'h80, 1'b0, 32'h0, 1'b0);
    check_stats("dis", 10, 5, 5);
    bp_if.bp_enable = 1'b1;
    check_lk("reen_snt", 32'h80, 1'b0, 32'hC0);
    do_update(32'h80, 1'b1, 32'hC0, 1'b0);
    check_lk("reen_wnt", 32'h80, 1'b0, 32'hC0);
    do_update(32'h80, 1'b1, 32'hC0, 1'b0);
    check_lk("reen_wt", 32'h80, 1'b1, 32'hC0);
    check_stats("reen", 12, 5, 7);

    // Same-cycle lookup and update of one entry: no bypass
    @(negedge clk);
    bp_if.lookup_pc        = 32'h80;
    bp_if.update_en        = 1'b1;
    bp_if.update_pc        = 32'h80;
    bp_if.update_taken     = 1'b0;
    bp_if.update_target    = 32'h0;
    bp_if.update_predicted = 1'b0;
    #1;
    check("nobypass_old", {31'b0, bp_if.predict_taken}, 32'd1);
    @(posedge clk);
    m_step(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
    #1;
    bp_if.update_en = 1'b0;
    check_lk("nobypass_new", 32'h80, 1'b0, 32'hC0);
    check_stats("nobypass", 13, 6, 7);

    // stats_clear beats a same-cycle count; table still trains
    do_update(32'h80, 1'b1, 32'hC0, 1'b1, 1'b1);
    check_stats("clr_upd", 0, 0, 0);
    check_lk("clr_upd_table", 32'h80, 1'b1, 32'hC0);

    // Saturation of bp_total (preloaded just below the top)
    @(negedge clk);
    force dut.total_q = 32'hFFFF_FFFE;
    #1;
    release dut.total_q;
    m_total = 64'hFFFF_FFFE;
    do_update(32'h80, 1'b1, 32'hC0, 1'b1);
    check("sat_reach", bp_if.bp_total, 32'hFFFF_FFFF);
    do_update(32'h80, 1'b0, 32'h0, 1'b1);
    check("sat_hold", bp_if.bp_total, 32'hFFFF_FFFF);
    check_stats("sat_model", m_total, m_correct, m_wrong);

    // Clear alone
    @(negedge clk);
    bp_if.stats_clear = 1'b1;
    @(posedge clk);
    m_step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    bp_if.stats_clear = 1'b0;
    check_stats("clr_only", 0, 0, 0);

    // Randomized phase against the model
    for (int it = 0; it < 400; it++) begin
      logic [31:0] lpc, upc, utg;
      bit          upd, clr, ut, en, pr;
      logic        ptk;
      logic [31:0] ptg;
      lpc = pool_pc();
      upc = pool_pc();
      en  = ($urandom_range(0, 3) != 0);
      upd = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      ut  = $urandom_range(0, 1);
      utg = $urandom() & 32'hFFFF_FFFC;
      m_predict(upc, 1'b1, ptk, ptg);
      pr  = ptk ^ ($urandom_range(0, 4) == 0);

      bp_if.bp_enable        = en;
      bp_if.lookup_pc        = lpc;
      bp_if.update_en        = upd;
      bp_if.update_pc        = upc;
      bp_if.update_taken     = ut;
      bp_if.update_target    = utg;
      bp_if.update_predicted = pr;
      bp_if.stats_clear      = clr;
      #1;
      m_predict(lpc, en, et, etg);
      check("rand_taken",  {31'b0, bp_if.predict_taken}, {31'b0, et});
      check("rand_target", bp_if.predict_target, etg);
      @(posedge clk);
      m_step(upd, clr, upc, ut, utg, pr);
      #1;
      check_stats("rand", m_total, m_correct, m_wrong);
    end
    bp_if.update_en   = 1'b0;
    bp_if.stats_clear = 1'b0;
    bp_if.bp_enable   = 1'b1;

    // Final sweep of every pool address
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] pc;
        pc = (t << 6) | (i << 2);
        m_predict(pc, 1'b1, et, etg);
        check_lk("sweep", pc, et, etg);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
